// File: rtl/led_pkg.sv
// Shared types and defaults for the LED strand frame buffer.
// Pixel packing is {b,g,r}, the order the strand serializer shifts them out.
package led_pkg;

  localparam int NUM_LEDS = 30;
  localparam int CLK_HZ   = 50_000_000;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    KICK,
    RUN
  } state_t;

  // 8x8 fractional scale: floor(pix * lvl / 256)
  function automatic logic [7:0] scale8(input logic [7:0] pix, input logic [7:0] lvl);
    logic [15:0] prod;
    prod = 16'(pix) * 16'(lvl);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/led_pixel_bank.sv
// One bank of pixel storage: DEPTH x 24-bit, single write port and a
// registered read port. Contents are deliberately not reset.
module led_pixel_bank
  import led_pkg::*;
#(
  parameter int DEPTH = NUM_LEDS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk50,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rgb_t          wdata,
  input  logic [AW-1:0] raddr,
  output rgb_t          rdata
);

  rgb_t mem [DEPTH];

  // write-first is irrelevant here: host and serializer never share a bank
  always_ff @(posedge clk50) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered pixel source for the LED strand serializer.
// The host fills the back bank and commits; the swap happens at the next
// frame start. Frames are paced by a refresh counter and each one begins
// with a KICK_CYCLES-wide restart pulse to the serializer.
// Optional build macro LED_BRIGHT_EN adds a global brightness input that
// scales every channel by bright/256.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int NUM_LEDS       = led_pkg::NUM_LEDS,
  parameter int REFRESH_CYCLES = CLK_HZ / 50,
  parameter int KICK_CYCLES    = 2,
  parameter int AW             = $clog2(NUM_LEDS)
) (
  input  logic          rst,
  input  logic          clk50,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_r,
  input  logic [7:0]    wr_g,
  input  logic [7:0]    wr_b,
  input  logic          wr_commit,
  output logic          wr_ready,
  output logic          ser_rst,
  input  logic [7:0]    ser_led,
  input  logic          ser_done,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          busy,
  output logic [15:0]   frame_count
`ifdef LED_BRIGHT_EN
  ,
  input  logic [7:0]    bright
`endif
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int KW = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_TOP   = CW'(REFRESH_CYCLES - 1);
  // the first KICK cycle itself is count 0, so the register restarts at 1
  // and frame starts land exactly REFRESH_CYCLES apart
  localparam logic [CW-1:0] CNT_KICK  = (REFRESH_CYCLES > 1) ? CW'(1) : '0;
  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_CYCLES - 1);
  localparam logic [AW:0]   LED_LIMIT = (AW+1)'(NUM_LEDS);
  localparam logic [8:0]    LAST_LED  = 9'(NUM_LEDS - 1);

  state_t        state, state_nx;
  logic          bank_sel, swap_pend, frame_valid;
  logic [CW-1:0] cnt;
  logic [KW-1:0] kick_cnt;
  logic          kick_first;
  logic          wr_ok;
  logic [8:0]    led_nx;
  logic [AW-1:0] rd_addr;
  logic          sel_q, valid_q;
  rgb_t          wr_pix;
  rgb_t          rd_pix [2];
  rgb_t          pix;

  // ---------------------------------------------------------------- FSM

  // state register; reset parks the serializer in IDLE (held in reset)
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state: refresh pacing, fixed-width kick, then wait for serializer
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cnt == CNT_TOP) state_nx = KICK;
      KICK:    if (kick_cnt == KICK_LAST) state_nx = RUN;
      RUN:     if (ser_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: serializer released only in RUN, host blocked only in KICK
  always_comb begin
    ser_rst  = 1'b1;
    wr_ready = 1'b1;
    busy     = 1'b0;
    case (state)
      KICK: begin
        wr_ready = 1'b0;
        busy     = 1'b1;
      end
      RUN: begin
        ser_rst = 1'b0;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------ frame control

  assign kick_first = (state == KICK) && (kick_cnt == '0);

  // refresh counter, kick timer, bank swap and frame bookkeeping
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      bank_sel    <= 1'b0;
      swap_pend   <= 1'b0;
      frame_valid <= 1'b0;
      cnt         <= '0;
      kick_cnt    <= '0;
      frame_count <= '0;
    end else begin
      kick_cnt <= (state == KICK) ? kick_cnt + 1'b1 : '0;

      // saturates so a long RUN leaves IDLE after a single cycle
      if (kick_first)          cnt <= CNT_KICK;
      else if (cnt != CNT_TOP) cnt <= cnt + 1'b1;

      if (kick_first) begin
        frame_count <= frame_count + 1'b1;
        if (swap_pend) begin
          bank_sel    <= ~bank_sel;
          frame_valid <= 1'b1;
          swap_pend   <= 1'b0;
        end
      end else if (wr_commit && wr_ready) begin
        swap_pend <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------- pixel memory

  assign wr_ok  = wr_en && wr_ready && ({1'b0, wr_addr} < LED_LIMIT);
  assign wr_pix = {wr_b, wr_g, wr_r};

  // host always targets the bank the serializer is not reading
  for (genvar i = 0; i < 2; i++) begin : g_bank
    localparam logic ID = 1'(i);
    led_pixel_bank #(
      .DEPTH (NUM_LEDS),
      .AW    (AW)
    ) u_bank (
      .clk50 (clk50),
      .we    (wr_ok && (bank_sel != ID)),
      .waddr (wr_addr),
      .wdata (wr_pix),
      .raddr (rd_addr),
      .rdata (rd_pix[i])
    );
  end

  // ---------------------------------------------------------- read path

  assign led_nx = {1'b0, ser_led} + 9'd1;

  // prefetch the pixel the serializer samples next; pixel 0 while it is held
  always_comb begin
    rd_addr = '0;
    if (state == RUN)
      rd_addr = (led_nx > LAST_LED) ? AW'(LAST_LED) : AW'(led_nx);
  end

  // bank select and valid travel alongside the bank read registers
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sel_q   <= bank_sel;
      valid_q <= frame_valid;
    end
  end

  assign pix = rd_pix[sel_q];

`ifdef LED_BRIGHT_EN
  // scaling sits on the read data so the pixel still arrives one cycle
  // after its address
  assign r = valid_q ? scale8(pix.r, bright) : 8'h00;
  assign g = valid_q ? scale8(pix.g, bright) : 8'h00;
  assign b = valid_q ? scale8(pix.b, bright) : 8'h00;
`else
  assign r = valid_q ? pix.r : 8'h00;
  assign g = valid_q ? pix.g : 8'h00;
  assign b = valid_q ? pix.b : 8'h00;
`endif

endmodule

// File: tb/tb_led_frame_buffer.sv
// Directed/randomized bench for led_frame_buffer with a serializer model and
// a bank-level reference model (two pixel arrays, active bank, pending swap).
module tb_led_frame_buffer;

  localparam int N  = 30;
  localparam int R  = 200;
  localparam int K  = 2;
  localparam int AW = $clog2(N);

  logic          rst, clk50;
  logic          wr_en, wr_commit, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_r, wr_g, wr_b;
  logic          ser_rst, ser_done, busy;
  logic [7:0]    ser_led, r, g, b;
  logic [15:0]   frame_count;
`ifdef LED_BRIGHT_EN
  logic [7:0]    bright;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;

  // reference model state
  logic [7:0] m_r [2][N];
  logic [7:0] m_g [2][N];
  logic [7:0] m_b [2][N];
  int m_sel, m_valid, m_swap, m_frames;

  led_frame_buffer #(
    .NUM_LEDS       (N),
    .REFRESH_CYCLES (R),
    .KICK_CYCLES    (K)
  ) dut (
    .rst         (rst),
    .clk50       (clk50),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_r        (wr_r),
    .wr_g        (wr_g),
    .wr_b        (wr_b),
    .wr_commit   (wr_commit),
    .wr_ready    (wr_ready),
    .ser_rst     (ser_rst),
    .ser_led     (ser_led),
    .ser_done    (ser_done),
    .r           (r),
    .g           (g),
    .b           (b),
    .busy        (busy),
    .frame_count (frame_count)
`ifdef LED_BRIGHT_EN
    ,
    .bright      (bright)
`endif
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;
  always @(posedge clk50) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // what the serializer should see for a stored channel value
  function automatic logic [7:0] expect_ch(input logic [7:0] v);
    if (m_valid == 0) return 8'h00;
`ifdef LED_BRIGHT_EN
    return 8'((int'(v) * int'(bright)) / 256);
`else
    return v;
`endif
  endfunction

  // one host cycle; callers only use it while the host port is open
  task automatic host_op(input bit en, input int a, input logic [7:0] pr, input logic [7:0] pg,
                         input logic [7:0] pb, input bit commit);
    @(posedge clk50); #1;
    wr_en = en; wr_addr = AW'(a); wr_r = pr; wr_g = pg; wr_b = pb; wr_commit = commit;
    if (en && a < N) begin
      m_r[1-m_sel][a] = pr; m_g[1-m_sel][a] = pg; m_b[1-m_sel][a] = pb;
    end
    if (commit) m_swap = 1;
    @(posedge clk50); #1;
    wr_en = 0; wr_commit = 0;
  endtask

  task automatic fill_random;
    for (int i = 0; i < N; i++)
      host_op(1, i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), 0);
  endtask

  // Waits for a frame start, checks the kick, plays a serializer through
  // all pixels, then finishes the frame. exp_period>0 checks spacing to the
  // previous start, <0 demands the start on the very next cycle.
  task automatic run_frame(input int exp_period, input bit kick_commit,
                           input int run_commit_at, input int hold);
    int waited;
    int a;
    logic [7:0] x, y, z;
    waited = 0;
    @(negedge clk50);
    while (busy !== 1'b1 && waited < 3*R) begin
      @(negedge clk50);
      waited++;
    end
    check("frame_start", 32'(busy), 32'd1);
    if (exp_period > 0) check("period", 32'(cyc - last_start), 32'(exp_period));
    if (exp_period < 0) check("idle_gap", 32'(waited), 32'd0);
    last_start = cyc;
    if (m_swap != 0) begin
      m_sel = 1 - m_sel; m_valid = 1; m_swap = 0;
    end
    m_frames++;
    check("kick_ser_rst", 32'(ser_rst), 32'd1);
    check("kick_ready", 32'(wr_ready), 32'd0);
    for (int k = 1; k < K; k++) begin
      @(posedge clk50); #1 wr_commit = kick_commit;
      @(negedge clk50);
      check("kick_ser_rst", 32'(ser_rst), 32'd1);
      check("kick_ready", 32'(wr_ready), 32'd0);
    end
    @(posedge clk50); #1 wr_commit = 0;
    @(negedge clk50);
    check("run_ser_rst", 32'(ser_rst), 32'd0);
    check("run_ready", 32'(wr_ready), 32'd1);
    check("run_busy", 32'(busy), 32'd1);
    check("frame_count", 32'(frame_count), 32'(m_frames & 16'hFFFF));
    for (int n = 0; n < N; n++) begin
      check($sformatf("pix%0d_r", n), 32'(r), 32'(expect_ch(m_r[m_sel][n])));
      check($sformatf("pix%0d_g", n), 32'(g), 32'(expect_ch(m_g[m_sel][n])));
      check($sformatf("pix%0d_b", n), 32'(b), 32'(expect_ch(m_b[m_sel][n])));
      if (n == N-1) break;
      @(posedge clk50); #1 ser_led = 8'(n);
      if (n == run_commit_at) begin
        a = $urandom_range(0, N-1);
        x = 8'($urandom_range(0, 255)); y = 8'($urandom_range(0, 255)); z = 8'($urandom_range(0, 255));
        wr_en = 1; wr_addr = AW'(a); wr_r = x; wr_g = y; wr_b = z; wr_commit = 1;
        m_r[1-m_sel][a] = x; m_g[1-m_sel][a] = y; m_b[1-m_sel][a] = z; m_swap = 1;
      end
      @(posedge clk50); #1 wr_en = 0; wr_commit = 0;
      @(negedge clk50);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk50);
      check("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clk50); #1 ser_done = 1;
    @(posedge clk50); #1 ser_done = 0; ser_led = 0;
    @(negedge clk50);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ser_rst", 32'(ser_rst), 32'd1);
  endtask

  initial begin
    int waited;
    rst = 1; wr_en = 0; wr_addr = '0; wr_r = 0; wr_g = 0; wr_b = 0; wr_commit = 0;
    ser_led = 0; ser_done = 0;
`ifdef LED_BRIGHT_EN
    bright = 8'd255;
`endif
    m_sel = 0; m_valid = 0; m_swap = 0; m_frames = 0;

    // reset state
    repeat (3) @(posedge clk50);
    @(negedge clk50);
    check("rst_ser_rst", 32'(ser_rst), 32'd1);
    check("rst_ready", 32'(wr_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_rgb", 32'({r, g, b}), 32'd0);
    @(posedge clk50); #1 rst = 0;
    last_start = cyc;

    // no commit yet: black frame
    run_frame(R, 0, -1, 0);

    // ramp pattern, an out-of-range write, a stray ser_done in IDLE, commit
    for (int i = 0; i < N; i++) host_op(1, i, 8'(i), 8'(2*i), 8'(3*i), 0);
    host_op(1, 31, 8'hFF, 8'hFF, 8'hFF, 0);
    @(posedge clk50); #1 ser_done = 1;
    @(posedge clk50); #1 ser_done = 0;
    host_op(0, 0, 0, 0, 0, 1);
    run_frame(R, 0, -1, 0);

    // fill the other bank, commit only inside KICK: must be lost
    fill_random();
    run_frame(R, 1, -1, 0);
    run_frame(R, 0, -1, 0);

    // write+commit mid-RUN, then a frame whose ser_done comes late
    run_frame(R, 0, 10, 0);
    run_frame(R, 0, -1, R);
    run_frame(-1, 0, -1, 0);

    // asynchronous reset in the middle of RUN
    waited = 0;
    @(negedge clk50);
    while (!(busy === 1'b1 && ser_rst === 1'b0) && waited < 3*R) begin
      @(negedge clk50);
      waited++;
    end
    check("reach_run", 32'({busy, ser_rst}), 32'b10);
    ser_led = 8'd5;
    repeat (5) @(negedge clk50);
    #3 rst = 1;
    #1;
    check("mid_rst_ser_rst", 32'(ser_rst), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_frame_count", 32'(frame_count), 32'd0);
    check("mid_rst_rgb", 32'({r, g, b}), 32'd0);
    m_sel = 0; m_valid = 0; m_swap = 0; m_frames = 0;
    ser_led = 0;
    @(posedge clk50); #1 rst = 0;
    last_start = cyc;

    // memories survive reset: show both banks again
`ifdef LED_BRIGHT_EN
    host_op(1, 0, 8'hFF, 8'h80, 8'h01, 0);
    bright = 8'd128;
`endif
    host_op(0, 0, 0, 0, 0, 1);
    run_frame(R, 0, -1, 0);
`ifdef LED_BRIGHT_EN
    bright = 8'($urandom_range(0, 255));
`endif
    host_op(0, 0, 0, 0, 0, 1);
    run_frame(R, 0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
